// File: rtl/n2_dmem_resp_pkg.sv
// Shared types for the n2 data-memory responder.
package n2_dmem_resp_pkg;

  localparam int unsigned DMEM_ADDR_W_DFLT = 14;
  localparam int unsigned DMEM_DATA_W      = 32;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic                   err;
    logic [DMEM_DATA_W-1:0] rdata;
  } dmem_resp_t;

  // Store and out-of-window responses carry no read data.
  function automatic logic [DMEM_DATA_W-1:0] resp_rdata(input dmem_resp_t r);
    return (r.we || r.err) ? '0 : r.rdata;
  endfunction

endpackage

// File: rtl/n2_dmem_bram.sv
// Single-port byte-enabled word RAM with registered, enable-gated read port.
module n2_dmem_bram
  import n2_dmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W_DFLT
) (
  input  logic                   clk,
  input  logic                   i_en,
  input  logic [3:0]             i_we,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [DMEM_DATA_W-1:0] i_wdata,
  output logic [DMEM_DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DMEM_DATA_W-1:0] r_mem [DEPTH];
  logic [DMEM_DATA_W-1:0] r_rdata;

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/n2_dmem_resp.sv
// LSU data-port responder: grant/throttle logic, on-chip RAM and a fixed-latency,
// in-order, holdable response pipeline.
module n2_dmem_resp
  import n2_dmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMEM_ADDR_W_DFLT,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned RESP_LAT  = 1,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_wstrb_i,
  output logic        data_gnt_o,
  output logic        data_ready_o,
  output logic [31:0] data_rdata_o,
  input  logic        hold_i,
  output logic        err_o
);

  localparam int unsigned CNT_W   = $clog2(MAX_OUTST + 1);
  localparam int unsigned TAG_LSB = ADDR_W + 2;

  logic             w_in_range;
  logic             w_accept;
  logic             w_fire;
  logic [3:0]       w_ram_we;
  logic [31:0]      w_ram_q;
  logic [CNT_W-1:0] r_outst;
  logic             r_s1_valid;
  logic             r_s1_we;
  logic             r_s1_err;
  logic [31:0]      r_rdata_last;
  dmem_resp_t       w_s1;
  dmem_resp_t       w_head;
  logic             w_unused_addr;

  assign w_unused_addr = ^data_addr_i[1:0];
  assign w_in_range    = (data_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign w_fire     = w_head.valid & ~hold_i;
  assign data_gnt_o = data_req_i & ~hold_i & ~reset &
                      ((r_outst < CNT_W'(MAX_OUTST)) | w_fire);
  assign w_accept   = data_req_i & data_gnt_o;
  assign w_ram_we   = {4{w_accept & data_we_i & w_in_range}} & data_wstrb_i;

  n2_dmem_bram #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk     (clk),
    .i_en    (~hold_i),
    .i_we    (w_ram_we),
    .i_addr  (data_addr_i[TAG_LSB-1:2]),
    .i_wdata (data_wdata_i),
    .o_rdata (w_ram_q)
  );

  // Stage 1 flags travel alongside the RAM output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_we    <= 1'b0;
      r_s1_err   <= 1'b0;
    end else if (!hold_i) begin
      r_s1_valid <= w_accept;
      r_s1_we    <= data_we_i;
      r_s1_err   <= ~w_in_range;
    end
  end

  always_comb begin
    w_s1       = '0;
    w_s1.valid = r_s1_valid;
    w_s1.we    = r_s1_we;
    w_s1.err   = r_s1_err;
    w_s1.rdata = w_ram_q;
  end

  generate
    if (RESP_LAT > 1) begin : g_pipe
      dmem_resp_t r_pipe [RESP_LAT-1];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(RESP_LAT) - 1; i++) r_pipe[i] <= '0;
        end else if (!hold_i) begin
          r_pipe[0] <= w_s1;
          for (int i = 1; i < int'(RESP_LAT) - 1; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign w_head = r_pipe[RESP_LAT-2];
    end else begin : g_no_pipe
      assign w_head = w_s1;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outst <= '0;
    end else begin
      case ({w_accept, w_fire})
        2'b10:   r_outst <= r_outst + CNT_W'(1);
        2'b01:   r_outst <= r_outst - CNT_W'(1);
        default: r_outst <= r_outst;
      endcase
    end
  end

  // Read data is frozen between responses so it only ever moves on a ready pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata_last <= '0;
    end else if (w_fire) begin
      r_rdata_last <= resp_rdata(w_head);
    end
  end

  assign data_ready_o = w_fire;
  assign err_o        = w_fire & w_head.err;
  assign data_rdata_o = w_fire ? resp_rdata(w_head) : r_rdata_last;

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(w_fire && (r_outst == '0)));
  a_max_outst: assert property (@(posedge clk) disable iff (reset)
    (r_outst <= CNT_W'(MAX_OUTST)));

endmodule

// File: tb/tb_n2_dmem_resp.sv
// Scoreboard bench for n2_dmem_resp: three instances (latency 1/3/4) share inputs except req.
module tb_n2_dmem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic        hold;
  logic [2:0]  gnt;
  logic [2:0]  ready;
  logic [2:0]  err;
  logic [31:0] rdata [3];

  logic [2:0]  gnt_s;
  logic [2:0]  ready_s;
  logic [2:0]  err_s;
  logic [31:0] rdata_s [3];
  int          cyc_s;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          lat_tab [3] = '{1, 3, 4};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    int          tgt;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  n2_dmem_resp #(.ADDR_W(14), .BASE_ADDR(32'h0), .RESP_LAT(1), .MAX_OUTST(4)) u_a (
    .clk(clk), .reset(rst), .data_req_i(req[0]), .data_we_i(we), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_wstrb_i(strb), .data_gnt_o(gnt[0]), .data_ready_o(ready[0]),
    .data_rdata_o(rdata[0]), .hold_i(hold), .err_o(err[0]));

  n2_dmem_resp #(.ADDR_W(14), .BASE_ADDR(32'h0), .RESP_LAT(3), .MAX_OUTST(1)) u_b (
    .clk(clk), .reset(rst), .data_req_i(req[1]), .data_we_i(we), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_wstrb_i(strb), .data_gnt_o(gnt[1]), .data_ready_o(ready[1]),
    .data_rdata_o(rdata[1]), .hold_i(hold), .err_o(err[1]));

  n2_dmem_resp #(.ADDR_W(14), .BASE_ADDR(32'h0), .RESP_LAT(4), .MAX_OUTST(4)) u_c (
    .clk(clk), .reset(rst), .data_req_i(req[2]), .data_we_i(we), .data_addr_i(addr),
    .data_wdata_i(wdata), .data_wstrb_i(strb), .data_gnt_o(gnt[2]), .data_ready_o(ready[2]),
    .data_rdata_o(rdata[2]), .hold_i(hold), .err_o(err[2]));

  // Called at the falling edge: latch outputs and retire any response against the scoreboard.
  task automatic sample();
    exp_t e;
    gnt_s   = gnt;
    ready_s = ready;
    err_s   = err;
    cyc_s   = cyc;
    for (int t = 0; t < 3; t++) begin
      rdata_s[t] = rdata[t];
      if (ready[t]) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].tgt != t) begin
          errors++;
          $display("FAIL resp_unexpected dut=%0d cyc=%0d got rdata=%h err=%b, required no response",
                   t, cyc, rdata[t], err[t]);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e.cyc || rdata[t] !== e.rdata || err[t] !== e.err) begin
            errors++;
            $display("FAIL resp dut=%0d got cyc=%0d rdata=%h err=%b, required cyc=%0d rdata=%h err=%b",
                     t, cyc, rdata[t], err[t], e.cyc, e.rdata, e.err);
          end
        end
      end else if (err[t] !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL err_without_ready dut=%0d cyc=%0d got err=%b, required 0", t, cyc, err[t]);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  // Hold a request on instance t until granted; push the response it must produce.
  task automatic do_op(input int t, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] erd, input logic eerr,
                       input int extra, output int acc);
    exp_t e;
    acc   = -1;
    req   = 3'b000;
    req[t] = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    strb  = s;
    for (int n = 0; n < 50 && acc < 0; n++) begin
      tick();
      if (gnt_s[t]) begin
        acc     = cyc_s;
        e.rdata = erd;
        e.err   = eerr;
        e.cyc   = acc + lat_tab[t] + extra;
        e.tgt   = t;
        exp_q.push_back(e);
      end
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout dut=%0d addr=%h got no grant in 50 cycles, required a grant", t, a);
    end
  endtask

  task automatic drain();
    req = 3'b000;
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; req = 3'b111; we = 1'b0;
    addr = '0; wdata = '0; strb = '0;
    tick();
    tick();
    checks++;
    if (gnt_s !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b required 000", gnt_s); end
    checks++;
    if (ready_s !== 3'b000) begin errors++; $display("FAIL reset_ready got %b required 000", ready_s); end
    checks++;
    if (err_s !== 3'b000) begin errors++; $display("FAIL reset_err got %b required 000", err_s); end
    for (int t = 0; t < 3; t++) begin
      checks++;
      if (rdata_s[t] !== 32'h0) begin
        errors++;
        $display("FAIL reset_rdata dut=%0d got %h required 0", t, rdata_s[t]);
      end
    end
    req = 3'b000;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_load();
    int a0, a1;
    do_op(0, 1'b1, 32'h100, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 0, a0);
    do_op(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0, a1);
    checks++;
    if (a1 !== a0 + 1) begin errors++; $display("FAIL b2b_grant got accept %0d required %0d", a1, a0 + 1); end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL store_load_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_byte_strobe();
    int a;
    do_op(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0, 0, a);
    do_op(0, 1'b1, 32'h22, 32'hABAB_ABAB, 4'b0100, 32'h0, 1'b0, 0, a);
    do_op(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hFFAB_FFFF, 1'b0, 0, a);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL strobe_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    int a0, a1;
    do_op(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 4, a0);
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gnt_s[0] !== 1'b0) begin errors++; $display("FAIL hold_gnt cyc=%0d got 1 required 0", cyc_s); end
      checks++;
      if (ready_s[0] !== 1'b0) begin errors++; $display("FAIL hold_ready cyc=%0d got 1 required 0", cyc_s); end
    end
    hold = 1'b0;
    do_op(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0, a1);
    checks++;
    if (a1 !== a0 + 5) begin errors++; $display("FAIL hold_release_grant got %0d required %0d", a1, a0 + 5); end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL hold_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_out_of_range();
    int a;
    do_op(0, 1'b1, 32'h0000_0000, 32'h5555_AAAA, 4'hF, 32'h0, 1'b0, 0, a);
    do_op(0, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 0, a);
    do_op(0, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 32'h0, 1'b1, 0, a);
    do_op(0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 32'h0, 1'b1, 0, a);
    do_op(0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h5555_AAAA, 1'b0, 0, a);
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL oor_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] model [4];
    logic [31:0] d;
    logic [3:0]  s;
    int a, first;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      model[i] = d;
      do_op(0, 1'b1, 32'h300 + 32'(4 * i), d, 4'hF, 32'h0, 1'b0, 0, a);
      if (i == 0) first = a;
    end
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      s = 4'($urandom_range(1, 15));
      for (int b = 0; b < 4; b++) if (s[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
      do_op(0, 1'b1, 32'h300 + 32'(4 * i), d, s, 32'h0, 1'b0, 0, a);
    end
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b0, 32'h300 + 32'(4 * i), 32'h0, 4'h0, model[i], 1'b0, 0, a);
    end
    checks++;
    if (a !== first + 11) begin errors++; $display("FAIL b2b_stream got last accept %0d required %0d", a, first + 11); end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_throttle();
    int a;
    int acc [4];
    for (int i = 0; i < 4; i++) begin
      do_op(1, 1'b1, 32'h40 + 32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF, 32'h0, 1'b0, 0, a);
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      do_op(1, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 4'h0, 32'h1000_0000 + 32'(i), 1'b0, 0, acc[i]);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (acc[i] !== acc[0] + 3 * i) begin
        errors++;
        $display("FAIL throttle_accept idx=%0d got %0d required %0d", i, acc[i], acc[0] + 3 * i);
      end
    end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL throttle_drain got %0d pending required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_flight();
    int a, k0;
    do_op(2, 1'b1, 32'h200, 32'h7777_0001, 4'hF, 32'h0, 1'b0, 0, a);
    drain();
    for (int i = 0; i < 3; i++) begin
      do_op(2, 1'b0, 32'h200, 32'h0, 4'h0, 32'h7777_0001, 1'b0, 0, a);
    end
    rst = 1'b1;
    req = 3'b000;
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (ready_s[2] !== 1'b0) begin errors++; $display("FAIL post_reset_ready cyc=%0d got 1 required 0", cyc_s); end
    end
    k0 = cyc;
    do_op(2, 1'b0, 32'h200, 32'h0, 4'h0, 32'h7777_0001, 1'b0, 0, a);
    checks++;
    if (a !== k0) begin errors++; $display("FAIL post_reset_grant got accept %0d required %0d", a, k0); end
    drain();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_drain got %0d pending required 0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; req = 3'b000; we = 1'b0;
    addr = '0; wdata = '0; strb = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_byte_strobe();
    test_hold();
    test_out_of_range();
    test_back_to_back();
    test_throttle();
    test_reset_mid_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
